// File: rtl/tx_rate_scheduler.sv
`timescale 1ns/1ps
// tx_rate_scheduler
// Enable/phase scheduler and run-control FSM for the I/Q transmit interpolation
// chain (mapper -> SRRC xSPS -> HB1 x2 -> HB2 x2 -> upconverter/DAC).
// A single free-running phase counter produces the symbol, sample and HB1
// enables and the zero-stuff slot selects. The FSM flushes the filters with
// zeros before symbols are released and drains them after the last symbol.
//
// Ports
//   sys_clk     system clock
//   reset       asynchronous, active-high
//   start       level, request transmission
//   stop        level, request end of transmission (priority over start)
//   sym_clk_en  strobe, period SAM_DIV*SPS
//   sam_clk_en  strobe, period SAM_DIV
//   hb1_clk_en  strobe, period SAM_DIV/2
//   sym_slot    high for the first sample period of each symbol
//   hb1_slot    high for the first SAM_DIV/2 cycles of each sample period
//   hb2_slot    high on even sys_clk cycles
//   data_gate   1 = force mapper outputs to zero at the SRRC input
//   lfsr_load   one-cycle pulse reseeding the symbol LFSRs
//   busy        state != IDLE
//   tx_active   state == RUN
//   state_o     IDLE=0, FLUSH=1, RUN=2, DRAIN=3
module tx_rate_scheduler #(
  parameter int unsigned SAM_DIV       = 4,
  parameter int unsigned SPS           = 4,
  parameter int unsigned FLUSH_SAMPLES = 104,
  parameter int unsigned DRAIN_SAMPLES = 104
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  output logic       sym_clk_en,
  output logic       sam_clk_en,
  output logic       hb1_clk_en,
  output logic       sym_slot,
  output logic       hb1_slot,
  output logic       hb2_slot,
  output logic       data_gate,
  output logic       lfsr_load,
  output logic       busy,
  output logic       tx_active,
  output logic [1:0] state_o
);

  localparam int unsigned PER     = SAM_DIV * SPS;
  localparam int unsigned PH_W    = $clog2(PER);
  localparam int unsigned HB1_DIV = SAM_DIV / 2;
  localparam int unsigned CNT_MAX = (FLUSH_SAMPLES > DRAIN_SAMPLES) ? FLUSH_SAMPLES : DRAIN_SAMPLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  logic [PH_W-1:0]  ph_q;
  logic [31:0]      ph_ext;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
  logic             data_gate_q, data_gate_d;
  logic             lfsr_load_q, lfsr_load_d;
  logic             busy_q, busy_d;
  logic             tx_active_q, tx_active_d;
  logic [1:0]       state_o_q, state_o_d;

  // Phase counter: free-running in every state, wraps at PER (power of two)
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) ph_q <= '0;
    else       ph_q <= ph_q + PH_W'(1);
  end

  // Enable/slot decode; modulo form keeps SAM_DIV=2 legal (hb1_clk_en == 1)
  assign ph_ext     = 32'(ph_q);
  assign sam_clk_en = (ph_ext % SAM_DIV) == (SAM_DIV - 1);
  assign hb1_clk_en = (ph_ext % HB1_DIV) == (HB1_DIV - 1);
  assign sym_clk_en = ph_ext == (PER - 1);
  assign sym_slot   = ph_ext < SAM_DIV;
  assign hb1_slot   = (ph_ext % SAM_DIV) < HB1_DIV;
  assign hb2_slot   = ~ph_q[0];

  // State, sample counter and output registers
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      smp_cnt_q   <= '0;
      data_gate_q <= 1'b1;
      lfsr_load_q <= 1'b0;
      busy_q      <= 1'b0;
      tx_active_q <= 1'b0;
      state_o_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      smp_cnt_q   <= smp_cnt_d;
      data_gate_q <= data_gate_d;
      lfsr_load_q <= lfsr_load_d;
      busy_q      <= busy_d;
      tx_active_q <= tx_active_d;
      state_o_q   <= state_o_d;
    end
  end

  // Next-state and sample counter
  always_comb begin
    state_d   = state_q;
    smp_cnt_d = smp_cnt_q;
    case (state_q)
      ST_IDLE: begin
        smp_cnt_d = '0;
        if (!stop && start) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (stop) begin
          state_d   = ST_IDLE;
          smp_cnt_d = '0;
        end else if (smp_cnt_q == CNT_W'(FLUSH_SAMPLES)) begin
          // Wait for the symbol boundary so RUN always begins on ph=0
          if (sym_clk_en) state_d = ST_RUN;
        end else if (sam_clk_en) begin
          smp_cnt_d = smp_cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        // stop only takes effect at a symbol boundary
        if (stop && sym_clk_en) begin
          state_d   = ST_DRAIN;
          smp_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        if (smp_cnt_q == CNT_W'(DRAIN_SAMPLES)) state_d = ST_IDLE;
        else if (sam_clk_en)                    smp_cnt_d = smp_cnt_q + CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state, registered above
  always_comb begin
    data_gate_d = 1'b1;
    lfsr_load_d = 1'b0;
    busy_d      = 1'b0;
    tx_active_d = 1'b0;
    state_o_d   = state_d;
    data_gate_d = (state_d != ST_RUN);
    busy_d      = (state_d != ST_IDLE);
    tx_active_d = (state_d == ST_RUN);
    lfsr_load_d = (state_q == ST_IDLE) && (state_d == ST_FLUSH);
  end

  assign data_gate = data_gate_q;
  assign lfsr_load = lfsr_load_q;
  assign busy      = busy_q;
  assign tx_active = tx_active_q;
  assign state_o   = state_o_q;

endmodule

// File: tb/tb_tx_rate_scheduler.sv
`timescale 1ns/1ps
// Randomized bench for tx_rate_scheduler against a cycle-count based model.
module tb_tx_rate_scheduler;

  localparam int SAM  = 4;
  localparam int SPSV = 4;
  localparam int PER  = SAM * SPSV;
  localparam int FL   = 8;
  localparam int DR   = 8;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       sym_clk_en, sam_clk_en, hb1_clk_en;
  logic       sym_slot, hb1_slot, hb2_slot;
  logic       data_gate, lfsr_load, busy, tx_active;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_errors = 0;

  // Model: cycles since reset release, state, sample pulses seen, load pulse
  int m_cyc   = 0;
  int m_state = 0;
  int m_cnt   = 0;
  int m_load  = 0;
  int stop_left = 0;
  int resets_done = 0;

  tx_rate_scheduler #(
    .SAM_DIV(SAM), .SPS(SPSV), .FLUSH_SAMPLES(FL), .DRAIN_SAMPLES(DR)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .start(start), .stop(stop),
    .sym_clk_en(sym_clk_en), .sam_clk_en(sam_clk_en), .hb1_clk_en(hb1_clk_en),
    .sym_slot(sym_slot), .hb1_slot(hb1_slot), .hb2_slot(hb2_slot),
    .data_gate(data_gate), .lfsr_load(lfsr_load), .busy(busy),
    .tx_active(tx_active), .state_o(state_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, obs, exp);
    end
  endtask

  // Expected outputs from cycle count and modelled state
  task automatic check_all();
    int ph;
    ph = m_cyc % PER;
    check_eq("sam_clk_en", 32'(sam_clk_en), 32'(ph % SAM == SAM - 1));
    check_eq("hb1_clk_en", 32'(hb1_clk_en), 32'(ph % (SAM / 2) == SAM / 2 - 1));
    check_eq("sym_clk_en", 32'(sym_clk_en), 32'(ph == PER - 1));
    check_eq("sym_slot",   32'(sym_slot),   32'(ph < SAM));
    check_eq("hb1_slot",   32'(hb1_slot),   32'(ph % SAM < SAM / 2));
    check_eq("hb2_slot",   32'(hb2_slot),   32'(ph % 2 == 0));
    check_eq("state_o",    32'(state_o),    32'(m_state));
    check_eq("data_gate",  32'(data_gate),  32'(m_state != 2));
    check_eq("busy",       32'(busy),       32'(m_state != 0));
    check_eq("tx_active",  32'(tx_active),  32'(m_state == 2));
    check_eq("lfsr_load",  32'(lfsr_load),  32'(m_load));
  endtask

  // Advance the model by one clock using the inputs seen at that edge
  task automatic model_step();
    int  ph;
    bit  sam, sym;
    ph  = m_cyc % PER;
    sam = (ph % SAM == SAM - 1);
    sym = (ph == PER - 1);
    m_load = 0;
    case (m_state)
      0: if (!stop && start) begin m_state = 1; m_cnt = 0; m_load = 1; end
      1: begin
        if (stop) m_state = 0;
        else if (m_cnt >= FL && sym) m_state = 2;
        else if (sam) m_cnt++;
      end
      2: if (stop && sym) begin m_state = 3; m_cnt = 0; end
      default: begin
        if (m_cnt >= DR) m_state = 0;
        else if (sam) m_cnt++;
      end
    endcase
    m_cyc++;
  endtask

  task automatic cycle();
    model_step();
    @(posedge sys_clk);
    #1;
    check_all();
  endtask

  task automatic model_reset();
    m_cyc = 0; m_state = 0; m_cnt = 0; m_load = 0;
  endtask

  task automatic drive_random(input int stop_p, input bit start_always);
    if (stop_left > 0) begin
      stop = 1'b1;
      stop_left--;
    end else begin
      stop = 1'b0;
      if ($urandom_range(stop_p - 1) == 0) stop_left = int'($urandom_range(24, 1));
    end
    start = start_always ? 1'b1 : ($urandom_range(3) == 0);
  endtask

  // Async reset in mid-operation; checked before any clock edge
  task automatic async_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge sys_clk);
    #1;
    check_all();
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    #2;
    check_all();
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    check_all();
    #2;
    reset = 1'b0;
    model_reset();

    // start and stop together in IDLE: nothing happens
    start = 1'b1;
    stop  = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    // idle free-running enables
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 64; i++) cycle();
    // start held: flush, run; then stop held across a symbol boundary
    start = 1'b1;
    for (int i = 0; i < 80; i++) cycle();
    start = 1'b0;
    stop  = 1'b1;
    for (int i = 0; i < 100; i++) cycle();
    stop  = 1'b0;

    for (int seg = 0; seg < 6; seg++) begin
      for (int i = 0; i < 1000; i++) begin
        drive_random((seg % 3 == 0) ? 40 : 300, seg[0]);
        cycle();
        if (resets_done < 4 && m_state == 2 && (m_cyc % PER) == 9) begin
          resets_done++;
          async_reset();
        end
      end
    end

    check_eq("resets_done", 32'(resets_done > 0), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
